ddr_axi_responder: RTL and testbench
====================================

# ddr_axi_responder

Synthesizable AXI responder for the combined-address (ARW) 128-bit DDR port that the SoC drives on `io_ddrA_*`. It sits on the memory-clock side in place of the DDR controller and answers read and write bursts from an on-chip block RAM. It is used for simulation, for bring-up without external DDR, and as the golden responder for the memory checker. It handles one transaction at a time: address, then data, then response.

## Interface
Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 128-bit words (default 16 KiB).
- BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to 16·2^DEPTH_LOG2.

Ports:
- io_memoryClk  in  1  sole clock; all logic is on the rising edge.
- io_memoryReset  in  1  reset, synchronous, active-high.
- io_ddrA_arw_valid / io_ddrA_arw_ready  in / out  1  address handshake.
- io_ddrA_arw_payload_addr  in  32  byte address.
- io_ddrA_arw_payload_id  in  8  transaction id.
- io_ddrA_arw_payload_len  in  8  beats minus 1.
- io_ddrA_arw_payload_size  in  3  must be 3'b100; any other value is treated as 3'b100.
- io_ddrA_arw_payload_burst  in  2  00 FIXED, 01 INCR, 10/11 treated as INCR.
- io_ddrA_arw_payload_lock  in  2  ignored.
- io_ddrA_arw_payload_write  in  1  1 = write, 0 = read.
- io_ddrA_w_valid / io_ddrA_w_ready  in / out  1  write data handshake.
- io_ddrA_w_payload_data  in  128  write data.
- io_ddrA_w_payload_strb  in  16  byte enables.
- io_ddrA_w_payload_id  in  8  ignored.
- io_ddrA_w_payload_last  in  1  last write beat.
- io_ddrA_b_valid / io_ddrA_b_ready  out / in  1  write response handshake.
- io_ddrA_b_payload_id  out  8  latched id.
- io_ddrA_b_payload_resp  out  2  00 OKAY, 10 SLVERR.
- io_ddrA_r_valid / io_ddrA_r_ready  out / in  1  read data handshake.
- io_ddrA_r_payload_data  out  128  read data.
- io_ddrA_r_payload_id  out  8  latched id.
- io_ddrA_r_payload_last  out  1  final beat.
- io_ddrA_r_payload_resp  out  2  per-beat response.

## Operation
- FSM states: IDLE, WRITE, WRESP, RD_FETCH, RD_DATA.
- IDLE:
  - arw_ready=1.
  - On arw_valid, latch addr/id/len/burst and clear the beat counter and error flag.
  - Go to WRITE if payload_write=1, else RD_FETCH.
- Word index is addr[DEPTH_LOG2+3:4]; addr[3:0] is ignored.
- A beat is in range when addr[31:DEPTH_LOG2+4] equals BASE_ADDR[31:DEPTH_LOG2+4].
- After each beat, INCR adds 16 to the address (32-bit wrap); FIXED holds the address.
- WRITE:
  - w_ready=1.
  - Each w handshake writes strobed bytes to RAM if the beat is in range and the counter ≤ len. Otherwise the RAM is untouched and the error flag is set.
  - The counter increments per beat.
  - On the w_last beat go to WRESP. The error flag is also set if that beat's counter ≠ len.
  - Beats beyond len+1 are absorbed without writing and flag an error.
- WRESP:
  - b_valid=1, resp = error ? 10 : 00.
  - On b_ready go to IDLE.
- RD_FETCH:
  - Issue the RAM read for the current address and go to RD_DATA.
- RD_DATA:
  - r_valid=1. data = RAM word, or zero if the beat is out of range. resp = 00, or 10 if out of range. last = (counter == len).
  - On r_ready: if last, go to IDLE; else advance address and counter and go to RD_FETCH.
- Any value of lock or size is accepted without error.

## Timing
- Reset values: arw_ready=0, w_ready=0, b_valid=0, r_valid=0. All payload outputs are 0. FSM is in IDLE; arw_ready rises the cycle after reset deasserts.
- Reset applied mid-burst aborts the transaction immediately: the FSM returns to IDLE and all valids drop on the next edge. RAM contents are retained.
- The address handshake takes 1 cycle.
- Write beats: 1 per cycle while w_valid is high. b_valid asserts the cycle after the w_last beat.
- Read: r_valid asserts 2 cycles after the address handshake. Throughput is 1 beat per 2 cycles, with one RD_FETCH bubble after each accepted beat.
- r and b payloads hold stable while valid is high and ready is low. Valid never drops without a handshake.
- arw_ready is low in every state except IDLE. A new address is accepted the cycle after the b or final r handshake.
- Data written by a write burst is visible to a read address accepted after that burst's b handshake.

## Test plan
- Single write then read:
  - Stimulus: write addr 0x40, len 0, strb 0xFFFF, data 0x0123…EF, then read 0x40.
  - Response: b resp 00 with the same id. r returns identical data, last=1, resp 00, r_valid 2 cycles after the arw handshake.
- INCR burst with partial strobes:
  - Stimulus: write len 3 at 0x100, beat 2 with strb 0x00FF, then read back with r_ready toggling.
  - Response: 4 beats; beat 2 upper 8 bytes keep their prior value; last only on beat 3; payload stable while stalled.
- FIXED burst:
  - Stimulus: write len 2 at 0x200 with data A, B, C, then read len 0 at 0x200.
  - Response: read returns C.
- Out-of-range access:
  - Stimulus: write 0x4000 (DEPTH_LOG2=10), then read len 1 at 0x3FF0.
  - Response: write b resp 10 and RAM unchanged. Read beat 0 resp 00; beat 1 data 0 with resp 10.
- Length mismatch:
  - Stimulus: write len 3 with w_last asserted on beat 1.
  - Response: b resp 10 one cycle later; beats 0–1 written.
- Reset during a read:
  - Stimulus: assert reset while r_valid=1 with r_ready=0.
  - Response: r_valid=0 next cycle; arw_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/ddr_axi_responder.sv
// ddr_axi_responder: block-RAM stand-in for the combined-address 128-bit DDR
// port. It serves one transaction at a time: address, then data, then response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once this block raises a valid (b, r), it holds that valid and
// its payload unchanged until the matching ready is seen.
module ddr_axi_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic         io_memoryClk,
    input  logic         io_memoryReset,
    input  logic         io_ddrA_arw_valid,
    output logic         io_ddrA_arw_ready,
    input  logic [31:0]  io_ddrA_arw_payload_addr,
    input  logic [7:0]   io_ddrA_arw_payload_id,
    input  logic [7:0]   io_ddrA_arw_payload_len,
    input  logic [2:0]   io_ddrA_arw_payload_size,
    input  logic [1:0]   io_ddrA_arw_payload_burst,
    input  logic [1:0]   io_ddrA_arw_payload_lock,
    input  logic         io_ddrA_arw_payload_write,
    input  logic         io_ddrA_w_valid,
    output logic         io_ddrA_w_ready,
    input  logic [127:0] io_ddrA_w_payload_data,
    input  logic [15:0]  io_ddrA_w_payload_strb,
    input  logic [7:0]   io_ddrA_w_payload_id,
    input  logic         io_ddrA_w_payload_last,
    output logic         io_ddrA_b_valid,
    input  logic         io_ddrA_b_ready,
    output logic [7:0]   io_ddrA_b_payload_id,
    output logic [1:0]   io_ddrA_b_payload_resp,
    output logic         io_ddrA_r_valid,
    input  logic         io_ddrA_r_ready,
    output logic [127:0] io_ddrA_r_payload_data,
    output logic [7:0]   io_ddrA_r_payload_id,
    output logic         io_ddrA_r_payload_last,
    output logic [1:0]   io_ddrA_r_payload_resp,
    output logic [2:0]   dbgState
);

    localparam int TagLsb = DEPTH_LOG2 + 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        WRESP    = 3'd2,
        RD_FETCH = 3'd3,
        RD_DATA  = 3'd4
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic                  arwRdy;
    logic [31:0]           curAddr;
    logic [7:0]            curId;
    logic [7:0]            curLen;
    logic                  isFixed;
    logic [8:0]            beatCnt;
    logic                  errFlag;
    logic [127:0]          readWord;
    logic [127:0]          mem [0:(1 << DEPTH_LOG2) - 1];

    logic                  inRange;
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic                  lastBeat;
    logic                  arwFire;
    logic                  wFire;
    logic                  bFire;
    logic                  rFire;
    logic                  ramWe;
    logic [31:0]           nextAddr;

    // Size, lock and the write-beat id carry no meaning for a single-port RAM.
    logic unusedInputs;
    assign unusedInputs = ^{io_ddrA_arw_payload_size, io_ddrA_arw_payload_lock,
                            io_ddrA_w_payload_id};

    assign inRange  = (curAddr[31:TagLsb] == BASE_ADDR[31:TagLsb]);
    assign wordIdx  = curAddr[TagLsb-1:4];
    assign lastBeat = (beatCnt == {1'b0, curLen});
    assign arwFire  = arwRdy && io_ddrA_arw_valid;
    assign wFire    = (state == WRITE) && io_ddrA_w_valid;
    assign bFire    = (state == WRESP) && io_ddrA_b_ready;
    assign rFire    = (state == RD_DATA) && io_ddrA_r_ready;
    assign ramWe    = wFire && inRange && (beatCnt <= {1'b0, curLen});
    assign nextAddr = isFixed ? curAddr : curAddr + 32'd16;

    // State register plus the latched transaction context.
    always_ff @(posedge io_memoryClk) begin
        if (io_memoryReset) begin
            state   <= IDLE;
            arwRdy  <= 1'b0;
            curAddr <= '0;
            curId   <= '0;
            curLen  <= '0;
            isFixed <= 1'b0;
            beatCnt <= '0;
            errFlag <= 1'b0;
        end else begin
            state  <= nextState;
            // Registered so that ready first rises one cycle after reset is released.
            arwRdy <= (nextState == IDLE);
            if (arwFire) begin
                curAddr <= io_ddrA_arw_payload_addr;
                curId   <= io_ddrA_arw_payload_id;
                curLen  <= io_ddrA_arw_payload_len;
                isFixed <= (io_ddrA_arw_payload_burst == 2'b00);
                beatCnt <= '0;
                errFlag <= 1'b0;
            end
            if (wFire) begin
                if (!inRange || (beatCnt > {1'b0, curLen}) ||
                    (io_ddrA_w_payload_last && !lastBeat))
                    errFlag <= 1'b1;
                curAddr <= nextAddr;
                // Saturate so a runaway burst cannot wrap back into the valid range.
                if (beatCnt != 9'h1FF)
                    beatCnt <= beatCnt + 9'd1;
            end
            if (rFire && !lastBeat) begin
                curAddr <= nextAddr;
                beatCnt <= beatCnt + 9'd1;
            end
        end
    end

    // RAM port: byte-strobed writes, registered read issued from RD_FETCH; no reset.
    always_ff @(posedge io_memoryClk) begin
        if (ramWe) begin
            for (int b = 0; b < 16; b++) begin
                if (io_ddrA_w_payload_strb[b])
                    mem[wordIdx][b*8 +: 8] <= io_ddrA_w_payload_data[b*8 +: 8];
            end
        end
        if (state == RD_FETCH)
            readWord <= mem[wordIdx];
    end

    // Next-state logic and all handshake/payload outputs, zero outside their state.
    always_comb begin
        nextState              = state;
        io_ddrA_arw_ready      = arwRdy;
        io_ddrA_w_ready        = 1'b0;
        io_ddrA_b_valid        = 1'b0;
        io_ddrA_b_payload_id   = '0;
        io_ddrA_b_payload_resp = 2'b00;
        io_ddrA_r_valid        = 1'b0;
        io_ddrA_r_payload_data = '0;
        io_ddrA_r_payload_id   = '0;
        io_ddrA_r_payload_last = 1'b0;
        io_ddrA_r_payload_resp = 2'b00;
        case (state)
            IDLE: begin
                if (arwFire)
                    nextState = io_ddrA_arw_payload_write ? WRITE : RD_FETCH;
            end
            WRITE: begin
                io_ddrA_w_ready = 1'b1;
                if (wFire && io_ddrA_w_payload_last)
                    nextState = WRESP;
            end
            WRESP: begin
                io_ddrA_b_valid        = 1'b1;
                io_ddrA_b_payload_id   = curId;
                io_ddrA_b_payload_resp = errFlag ? 2'b10 : 2'b00;
                if (bFire)
                    nextState = IDLE;
            end
            RD_FETCH: begin
                nextState = RD_DATA;
            end
            RD_DATA: begin
                io_ddrA_r_valid        = 1'b1;
                io_ddrA_r_payload_data = inRange ? readWord : '0;
                io_ddrA_r_payload_id   = curId;
                io_ddrA_r_payload_last = lastBeat;
                io_ddrA_r_payload_resp = inRange ? 2'b00 : 2'b10;
                if (rFire)
                    nextState = lastBeat ? IDLE : RD_FETCH;
            end
            default: nextState = IDLE;
        endcase
    end

    assign dbgState = state;

endmodule

// File: tb/tb_ddr_axi_responder.sv
// Directed bench for ddr_axi_responder: a table of single-beat transfers plus
// hand-written multi-beat, error and reset sequences.
module tb_ddr_axi_responder;

    logic         clk;
    logic         rst;
    logic         arwValid;
    logic         arwReady;
    logic [31:0]  arwAddr;
    logic [7:0]   arwId;
    logic [7:0]   arwLen;
    logic [2:0]   arwSize;
    logic [1:0]   arwBurst;
    logic [1:0]   arwLock;
    logic         arwWrite;
    logic         wValid;
    logic         wReady;
    logic [127:0] wData;
    logic [15:0]  wStrb;
    logic [7:0]   wId;
    logic         wLast;
    logic         bValid;
    logic         bReady;
    logic [7:0]   bId;
    logic [1:0]   bResp;
    logic         rValid;
    logic         rReady;
    logic [127:0] rData;
    logic [7:0]   rId;
    logic         rLast;
    logic [1:0]   rResp;
    logic [2:0]   dbgState;

    int checks   = 0;
    int failures = 0;

    logic [127:0] expQ[$];

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [7:0]   id;
        logic [127:0] data;
        logic [15:0]  strb;
        logic [127:0] expData;
        logic [1:0]   expResp;
    } vecT;

    vecT vecs[11];

    localparam logic [127:0] Data0  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] AllA   = {32{4'hA}};
    localparam logic [127:0] All5   = {32{4'h5}};
    localparam logic [127:0] Mixed  = 128'hAAAAAAAA_55555555_AAAAAAAA_55555555;
    localparam logic [127:0] Cafe   = 128'hCAFEF00D_DEADBEEF_0BADC0DE_12345678;
    localparam logic [127:0] AllF   = {128{1'b1}};
    localparam logic [127:0] Prior  = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

    ddr_axi_responder dut (
        .io_memoryClk              (clk),
        .io_memoryReset            (rst),
        .io_ddrA_arw_valid         (arwValid),
        .io_ddrA_arw_ready         (arwReady),
        .io_ddrA_arw_payload_addr  (arwAddr),
        .io_ddrA_arw_payload_id    (arwId),
        .io_ddrA_arw_payload_len   (arwLen),
        .io_ddrA_arw_payload_size  (arwSize),
        .io_ddrA_arw_payload_burst (arwBurst),
        .io_ddrA_arw_payload_lock  (arwLock),
        .io_ddrA_arw_payload_write (arwWrite),
        .io_ddrA_w_valid           (wValid),
        .io_ddrA_w_ready           (wReady),
        .io_ddrA_w_payload_data    (wData),
        .io_ddrA_w_payload_strb    (wStrb),
        .io_ddrA_w_payload_id      (wId),
        .io_ddrA_w_payload_last    (wLast),
        .io_ddrA_b_valid           (bValid),
        .io_ddrA_b_ready           (bReady),
        .io_ddrA_b_payload_id      (bId),
        .io_ddrA_b_payload_resp    (bResp),
        .io_ddrA_r_valid           (rValid),
        .io_ddrA_r_ready           (rReady),
        .io_ddrA_r_payload_data    (rData),
        .io_ddrA_r_payload_id      (rId),
        .io_ddrA_r_payload_last    (rLast),
        .io_ddrA_r_payload_resp    (rResp),
        .dbgState                  (dbgState)
    );

    // Clock and hard watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Drivers: each task starts and ends just after a rising edge.
    task automatic sendAddr(input logic wr, input logic [31:0] addr, input logic [7:0] id,
                            input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        arwValid = 1'b1; arwWrite = wr; arwAddr = addr; arwId = id;
        arwLen = len; arwBurst = burst; arwSize = 3'b100; arwLock = 2'b00;
        do begin @(negedge clk); n++; end while (!arwReady && n < 20);
        if (!arwReady) begin
            timeoutFail("arw");
            arwValid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arwValid = 1'b0;
    endtask

    task automatic sendBeat(input logic [127:0] data, input logic [15:0] strb, input logic last);
        int n = 0;
        wValid = 1'b1; wData = data; wStrb = strb; wLast = last; wId = 8'hEE;
        do begin @(negedge clk); n++; end while (!wReady && n < 20);
        if (!wReady) begin
            timeoutFail("w");
            wValid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        wValid = 1'b0; wLast = 1'b0;
    endtask

    task automatic getB(input logic [7:0] expId, input logic [1:0] expResp, input string name);
        int n = 0;
        bReady = 1'b1;
        do begin @(negedge clk); n++; end while (!bValid && n < 20);
        if (!bValid) begin
            timeoutFail({name, "_b"});
            bReady = 1'b0;
            return;
        end
        chk({name, "_blat"}, 128'(n), 128'(1));
        chk({name, "_bid"}, 128'(bId), 128'(expId));
        chk({name, "_bresp"}, 128'(bResp), 128'(expResp));
        @(posedge clk); #1;
        bReady = 1'b0;
    endtask

    task automatic getR(input logic [127:0] expData, input logic [7:0] expId,
                        input logic [1:0] expResp, input logic expLast,
                        input int stall, input string name);
        int n = 0;
        rReady = 1'b0;
        do begin @(negedge clk); n++; end while (!rValid && n < 20);
        if (!rValid) begin
            timeoutFail({name, "_r"});
            return;
        end
        chk({name, "_rlat"}, 128'(n), 128'(2));
        for (int s = 0; s < stall; s++) begin
            chk({name, "_stall_data"}, rData, expData);
            @(negedge clk);
        end
        chk({name, "_rvalid"}, 128'(rValid), 128'(1));
        chk({name, "_rdata"}, rData, expData);
        chk({name, "_rid"}, 128'(rId), 128'(expId));
        chk({name, "_rresp"}, 128'(rResp), 128'(expResp));
        chk({name, "_rlast"}, 128'(rLast), 128'(expLast));
        rReady = 1'b1;
        @(posedge clk); #1;
        rReady = 1'b0;
    endtask

    task automatic writeOne(input logic [31:0] addr, input logic [7:0] id, input logic [127:0] data);
        sendAddr(1'b1, addr, id, 8'd0, 2'b01);
        sendBeat(data, 16'hFFFF, 1'b1);
        getB(id, 2'b00, "prefill");
    endtask

    // Stimulus and checking.
    initial begin
        logic [127:0] e;
        int n;

        rst = 1'b1;
        arwValid = 1'b0; arwAddr = '0; arwId = '0; arwLen = '0; arwSize = '0;
        arwBurst = '0; arwLock = '0; arwWrite = 1'b0;
        wValid = 1'b0; wData = '0; wStrb = '0; wId = '0; wLast = 1'b0;
        bReady = 1'b0; rReady = 1'b0;

        vecs[0]  = '{1'b1, 32'h40,   8'h11, Data0, 16'hFFFF, '0,    2'b00};
        vecs[1]  = '{1'b0, 32'h40,   8'h12, '0,    16'h0,    Data0, 2'b00};
        vecs[2]  = '{1'b1, 32'h50,   8'h21, AllA,  16'hFFFF, '0,    2'b00};
        vecs[3]  = '{1'b1, 32'h50,   8'h22, All5,  16'h0F0F, '0,    2'b00};
        vecs[4]  = '{1'b0, 32'h5C,   8'h23, '0,    16'h0,    Mixed, 2'b00};
        vecs[5]  = '{1'b1, 32'h0,    8'h31, Cafe,  16'hFFFF, '0,    2'b00};
        vecs[6]  = '{1'b1, 32'h4000, 8'h32, AllF,  16'hFFFF, '0,    2'b10};
        vecs[7]  = '{1'b0, 32'h0,    8'h33, '0,    16'h0,    Cafe,  2'b00};
        vecs[8]  = '{1'b0, 32'h4000, 8'h34, '0,    16'h0,    '0,    2'b10};
        vecs[9]  = '{1'b1, 32'h50,   8'h35, AllF,  16'h0000, '0,    2'b00};
        vecs[10] = '{1'b0, 32'h50,   8'h36, '0,    16'h0,    Mixed, 2'b00};

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arw_ready", 128'(arwReady), 128'(0));
        chk("rst_w_ready", 128'(wReady), 128'(0));
        chk("rst_b_valid", 128'(bValid), 128'(0));
        chk("rst_r_valid", 128'(rValid), 128'(0));
        chk("rst_r_data", rData, 128'(0));
        chk("rst_b_id", 128'(bId), 128'(0));
        chk("rst_state", 128'(dbgState), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_arw_ready_early", 128'(arwReady), 128'(0));
        @(negedge clk);
        chk("rel_arw_ready", 128'(arwReady), 128'(1));
        @(posedge clk); #1;

        // Single-beat table.
        for (int i = 0; i < 11; i++) begin
            sendAddr(vecs[i].wr, vecs[i].addr, vecs[i].id, 8'd0, 2'b01);
            if (vecs[i].wr) begin
                sendBeat(vecs[i].data, vecs[i].strb, 1'b1);
                getB(vecs[i].id, vecs[i].expResp, $sformatf("vec%0d", i));
            end else begin
                getR(vecs[i].expData, vecs[i].id, vecs[i].expResp, 1'b1, 0,
                     $sformatf("vec%0d", i));
            end
        end

        // INCR burst with a partial strobe on beat 2, read back with stalls.
        writeOne(32'h120, 8'h40, Prior);
        sendAddr(1'b1, 32'h100, 8'h43, 8'd3, 2'b01);
        sendBeat({4{32'hB000_0000}}, 16'hFFFF, 1'b0);
        sendBeat({4{32'hB000_0001}}, 16'hFFFF, 1'b0);
        sendBeat({4{32'h2222_2222}}, 16'h00FF, 1'b0);
        sendBeat({4{32'hB000_0003}}, 16'hFFFF, 1'b1);
        getB(8'h43, 2'b00, "incr");
        expQ.push_back({4{32'hB000_0000}});
        expQ.push_back({4{32'hB000_0001}});
        expQ.push_back(128'hFFEEDDCC_BBAA9988_22222222_22222222);
        expQ.push_back({4{32'hB000_0003}});
        sendAddr(1'b0, 32'h100, 8'h44, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            e = expQ.pop_front();
            getR(e, 8'h44, 2'b00, (i == 3), (i * 5) % 4, $sformatf("incr_rd%0d", i));
        end

        // FIXED burst: the last beat wins.
        sendAddr(1'b1, 32'h200, 8'h45, 8'd2, 2'b00);
        sendBeat({8{16'hAAA1}}, 16'hFFFF, 1'b0);
        sendBeat({8{16'hBBB2}}, 16'hFFFF, 1'b0);
        sendBeat({8{16'hCCC3}}, 16'hFFFF, 1'b1);
        getB(8'h45, 2'b00, "fixed");
        sendAddr(1'b0, 32'h200, 8'h46, 8'd0, 2'b01);
        getR({8{16'hCCC3}}, 8'h46, 2'b00, 1'b1, 0, "fixed_rd");

        // Read crossing the top of the RAM window.
        writeOne(32'h3FF0, 8'h47, Prior);
        sendAddr(1'b0, 32'h3FF0, 8'h48, 8'd1, 2'b01);
        getR(Prior, 8'h48, 2'b00, 1'b0, 0, "oor_rd0");
        getR(128'(0), 8'h48, 2'b10, 1'b1, 0, "oor_rd1");

        // Early w_last: beats written, error response.
        sendAddr(1'b1, 32'h300, 8'h51, 8'd3, 2'b01);
        sendBeat({4{32'hE000_0000}}, 16'hFFFF, 1'b0);
        sendBeat({4{32'hE000_0001}}, 16'hFFFF, 1'b1);
        getB(8'h51, 2'b10, "lenmis");
        sendAddr(1'b0, 32'h300, 8'h52, 8'd1, 2'b01);
        getR({4{32'hE000_0000}}, 8'h52, 2'b00, 1'b0, 0, "lenmis_rd0");
        getR({4{32'hE000_0001}}, 8'h52, 2'b00, 1'b1, 0, "lenmis_rd1");

        // Reset while a read beat is stalled.
        sendAddr(1'b0, 32'h40, 8'h61, 8'd0, 2'b01);
        rReady = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rValid && n < 20);
        if (!rValid) timeoutFail("rstrd_r");
        rst = 1'b1;
        @(negedge clk);
        chk("rstrd_r_valid", 128'(rValid), 128'(0));
        chk("rstrd_arw_ready_in_rst", 128'(arwReady), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rstrd_arw_ready", 128'(arwReady), 128'(1));
        @(posedge clk); #1;
        sendAddr(1'b0, 32'h40, 8'h62, 8'd0, 2'b01);
        getR(Data0, 8'h62, 2'b00, 1'b1, 0, "retain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
